// File: rtl/sseg_scan_mux.sv
// Eight-digit multiplexed seven-segment scanner: per-slot timing, per-frame input
// snapshot, anti-ghosting blank window, digit enable and leading-zero suppression.
//
// state    | meaning
// ST_SYNC  | first clock after reset: load snapshot, start frame at slot 0
// ST_SCAN  | free-running slot counter and digit rotation
module sseg_scan_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] hex_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  hex_out,
  output logic [7:0]  an,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {ST_SYNC, ST_SCAN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   hex_snap_q, hex_snap_d;
  logic [7:0]    dp_snap_q, dp_snap_d;
  logic [7:0]    en_snap_q, en_snap_d;
  logic          lz_snap_q, lz_snap_d;
  logic [3:0]    hex_out_q, hex_out_d;
  logic [7:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic          load;
  logic          hi_zero;
  logic [7:0]    zero_above;
  logic          lit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hex_snap_d = hex_snap_q;
    dp_snap_d  = dp_snap_q;
    en_snap_d  = en_snap_q;
    lz_snap_d  = lz_snap_q;
    load       = 1'b0;

    unique case (state_q)
      ST_SYNC: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
        idx_d   = 3'd0;
        load    = 1'b1;
      end
      ST_SCAN: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          load  = (idx_q == 3'd7);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    if (load) begin
      hex_snap_d = hex_in;
      dp_snap_d  = dp_in;
      en_snap_d  = digit_en;
      lz_snap_d  = lz_blank;
    end
    fs_d = load;

    // zero_above[i]: nibbles i..7 of the snapshot are all zero
    hi_zero    = 1'b1;
    zero_above = '0;
    for (int i = 7; i >= 0; i--) begin
      hi_zero       = hi_zero & (hex_snap_d[4*i +: 4] == 4'h0);
      zero_above[i] = hi_zero;
    end

    lit = en_snap_d[idx_d] & ~(lz_snap_d & (idx_d != 3'd0) & zero_above[idx_d]);

    hex_out_d = hex_snap_d[{idx_d, 2'b00} +: 4];
    an_d      = 8'hFF;
    dp_d      = 1'b1;
    if ((cnt_d >= BLANK_END) && lit) begin
      an_d[idx_d] = 1'b0;
      dp_d        = ~dp_snap_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SYNC;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      hex_snap_q <= '0;
      dp_snap_q  <= '0;
      en_snap_q  <= '0;
      lz_snap_q  <= 1'b0;
      hex_out_q  <= 4'h0;
      an_q       <= 8'hFF;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hex_snap_q <= hex_snap_d;
      dp_snap_q  <= dp_snap_d;
      en_snap_q  <= en_snap_d;
      lz_snap_q  <= lz_snap_d;
      hex_out_q  <= hex_out_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign hex_out     = hex_out_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_sseg_scan_mux;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] hex_in = 32'h7654_3210;
  logic [7:0]  dp_in = 8'h00;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_blank = 1'b0;
  logic [3:0]  hex_out;
  logic [7:0]  an;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fs = -1;

  sseg_scan_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .hex_in(hex_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .hex_out(hex_out), .an(an),
    .dp(dp), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full frame starting at the next rising edge; lit/dpm are the
  // hand-derived per-digit lit and decimal-point expectations.
  task automatic run_frame(input logic [31:0] hx, input logic [7:0] lit,
                           input logic [7:0] dpm, input int chg_slot,
                           input logic [31:0] chg_hex);
    logic [7:0] exp_an;
    logic       exp_dp;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        exp_an = 8'hFF;
        exp_dp = 1'b1;
        if (c >= 1 && lit[s]) begin
          exp_an    = 8'hFF;
          exp_an[s] = 1'b0;
          exp_dp    = ~dpm[s];
        end
        check("digit_idx", {29'd0, digit_idx}, s);
        check("hex_out", {28'd0, hex_out}, {28'd0, hx[4*s +: 4]});
        check("an", {24'd0, an}, {24'd0, exp_an});
        check("dp", {31'd0, dp}, {31'd0, exp_dp});
        check("frame_start", {31'd0, frame_start}, (s == 0 && c == 0) ? 1 : 0);
        if (s == chg_slot && c == 1) hex_in = chg_hex;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    check("an_onehot", {31'd0, ($countones(~an) <= 1)}, 1);
    if (!reset_n) last_fs = -1;
    else if (frame_start) begin
      if (last_fs >= 0) check("fs_period", cyc - last_fs, 32);
      last_fs = cyc;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_an", {24'd0, an}, 32'hFF);
    check("rst_dp", {31'd0, dp}, 1);
    check("rst_idx", {29'd0, digit_idx}, 0);
    check("rst_fs", {31'd0, frame_start}, 0);
    check("rst_hex", {28'd0, hex_out}, 0);
    reset_n = 1'b1;

    run_frame(32'h7654_3210, 8'hFF, 8'h00, -1, 32'h0);

    hex_in   = 32'h0000_0A05;
    lz_blank = 1'b1;
    run_frame(32'h0000_0A05, 8'b0000_0111, 8'h00, -1, 32'h0);
    lz_blank = 1'b0;
    run_frame(32'h0000_0A05, 8'hFF, 8'h00, -1, 32'h0);

    hex_in = 32'h1111_1111;
    run_frame(32'h1111_1111, 8'hFF, 8'h00, 3, 32'h2222_2222);
    run_frame(32'h2222_2222, 8'hFF, 8'h00, -1, 32'h0);

    digit_en = 8'b1010_1010;
    dp_in    = 8'h02;
    run_frame(32'h2222_2222, 8'b1010_1010, 8'h02, -1, 32'h0);

    // 22 negedges in: last sample was slot 5, cnt 1; reset lands between edges
    repeat (22) @(negedge clk);
    check("pre_rst_idx", {29'd0, digit_idx}, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_an", {24'd0, an}, 32'hFF);
    check("mid_rst_dp", {31'd0, dp}, 1);
    check("mid_rst_idx", {29'd0, digit_idx}, 0);
    check("mid_rst_fs", {31'd0, frame_start}, 0);
    repeat (3) begin
      @(negedge clk);
      check("hold_rst_an", {24'd0, an}, 32'hFF);
      check("hold_rst_idx", {29'd0, digit_idx}, 0);
    end
    reset_n = 1'b1;
    run_frame(32'h2222_2222, 8'b1010_1010, 8'h02, -1, 32'h0);
    run_frame(32'h2222_2222, 8'b1010_1010, 8'h02, -1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot (range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYCLES, default 2000, anti-ghosting clocks at start of each slot (range 1..REFRESH_DIV-2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port hex_in  input  32  eight nibbles, digit i = hex_in[4i+3:4i], digit 0 rightmost.
REQ-006 SHALL have port dp_in  input  8  decimal point request per digit, active-high.
REQ-007 SHALL have port digit_en  input  8  per-digit enable, active-high; disabled digit never lit.
REQ-008 SHALL have port lz_blank  input  1  leading-zero blanking enable.
REQ-009 SHALL have port hex_out  output  4  nibble for current digit, feeds the hex-to-segment decoder.
REQ-010 SHALL have port an  output  8  digit anodes, active-low, one-hot-low or all-high.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.
REQ-012 SHALL have port digit_idx  output  3  index of current slot.
REQ-013 SHALL have port frame_start  output  1  one-clock pulse when slot 0 begins.

Function
REQ-014 SHALL keep slot counter cnt counting 0..REFRESH_DIV-1, wrapping to 0; on wrap digit_idx increments modulo 8 (7 -> 0).
REQ-015 SHALL snapshot hex_in, dp_in, digit_en, lz_blank into internal registers on the clock where digit_idx changes 7 -> 0; inputs outside that edge have no effect until next frame.
REQ-016 SHALL assert frame_start for exactly the clock in which digit_idx first equals 0 with cnt = 0 (first frame after reset included).
REQ-017 SHALL drive all outputs from registers; hex_out, an, dp reflect the new digit_idx in the same clock that digit_idx updates.
REQ-018 SHALL hold an = 8'hFF and dp = 1 while cnt < BLANK_CYCLES (anti-ghosting window).
REQ-019 SHALL, for cnt >= BLANK_CYCLES, drive an[digit_idx] = 0, all other bits 1, unless the digit is suppressed.
REQ-020 SHALL suppress digit i (an all 1, dp 1) when snapshot digit_en[i] = 0.
REQ-021 SHALL suppress digit i when snapshot lz_blank = 1, i != 0, and snapshot nibbles i..7 are all zero; digit 0 never blanked by this rule.
REQ-022 SHALL drive dp = ~snapshot dp_in[i] when digit i is lit, independent of the nibble value.
REQ-023 SHALL drive hex_out = snapshot nibble of digit_idx at all times, including blank windows.
REQ-024 SHALL never drive more than one an bit low in any clock.

Reset
REQ-025 SHALL, while reset_n = 0, force cnt = 0, digit_idx = 0, snapshots = 0, hex_out = 4'h0, an = 8'hFF, dp = 1, frame_start = 0, independent of clk.
REQ-026 SHALL, on the first clock after reset_n deasserts, load snapshot from inputs and pulse frame_start; slot 0 blank window begins then.
REQ-027 SHALL abort any slot on reset assertion mid-operation; no anode remains low during reset.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-028 SHALL check: reset release, hex_in=32'h76543210, digit_en=FF, lz_blank=0 -> digit_idx steps 0..7 every 4 clocks; per slot an=FF for 1 clock then ~(1<<i) for 3; hex_out=i.
REQ-029 SHALL check: hex_in=32'h00000A05, lz_blank=1 -> digits 0,1,2 lit (5,0,A), digits 3..7 an=FF; lz_blank=0 -> all eight lit.
REQ-030 SHALL check: hex_in changed from 32'h11111111 to 32'h22222222 during slot 3 -> slots 3..7 still show 1, next frame shows 2 from slot 0.
REQ-031 SHALL check: digit_en=8'b10101010, dp_in=8'h02 -> even digits never lit; dp=0 only during lit portion of slot 1.
REQ-032 SHALL check: reset_n pulled low mid slot 5 (asynchronously, between edges) -> an=FF, dp=1, digit_idx=0 immediately; after release frame_start pulses once, scan restarts at slot 0.
REQ-033 SHALL check throughout all tests: popcount(~an) <= 1 and frame_start period = 32 clocks.
